// File: rtl/my_bus_responder.sv
// my_bus_responder: two-stage bus beat processor feeding a result FIFO.
//
// A beat on the bus (valid=1) is captured into stage 1 at the rising edge.
// On the next edge the stage-1 operands are combined according to the opcode
// and the result is pushed into a DEPTH-entry FIFO. The bus has no
// backpressure, so a push that meets a full FIFO with no simultaneous pop is
// dropped. Each drop raises drop for one cycle and bumps a saturating
// counter. The FIFO head is presented directly from storage.
//
// Opcode c: 0 = a+b, 1 = a-b, 2 = a&b, 3 = a^b (all modulo 2^32).
//
// Parameters
//   DEPTH  FIFO entries; must be a power of two and at least 2.
//   CNT_W  width of drop_count.
//
// Ports
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   valid       in   bus beat qualifier
//   a, b        in   32-bit operands
//   c           in   2-bit opcode
//   out_valid   out  FIFO head holds a result
//   out_ready   in   downstream accept; ignored while out_valid=0
//   out_result  out  result at FIFO head
//   out_c       out  opcode of FIFO head entry
//   level       out  FIFO occupancy, 0..DEPTH
//   drop        out  one-cycle pulse after a beat is discarded
//   drop_count  out  saturating count of discarded beats
module my_bus_responder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  input  logic [1:0]             c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [1:0]             out_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [LvlW-1:0]  FullLevel = LvlW'(DEPTH);
  localparam logic [LvlW-1:0]  LvlOne    = LvlW'(1);
  localparam logic [PtrW-1:0]  PtrOne    = PtrW'(1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAnd = 2'd2,
    OpXor = 2'd3
  } op_e;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the beat
  // ---------------------------------------------------------------------------
  logic        s1_valid_q;
  logic [1:0]  s1_op_q;
  logic [31:0] s1_a_q;
  logic [31:0] s1_b_q;

  // Operand registers load only on a valid beat so that undriven bus values
  // between beats never reach the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= valid;
      if (valid) begin
        s1_op_q <= c;
        s1_a_q  <= a;
        s1_b_q  <= b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compute
  // ---------------------------------------------------------------------------
  logic [31:0] s2_result;

  always_comb begin
    s2_result = '0;
    unique case (op_e'(s1_op_q))
      OpAdd:   s2_result = s1_a_q + s1_b_q;
      OpSub:   s2_result = s1_a_q - s1_b_q;
      OpAnd:   s2_result = s1_a_q & s1_b_q;
      OpXor:   s2_result = s1_a_q ^ s1_b_q;
      default: s2_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [LvlW-1:0]  level_q, level_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic full;
  logic pop;
  logic push_ok;

  assign out_valid = (level_q != '0);
  assign full      = (level_q == FullLevel);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok   = s1_valid_q & (~full | pop);

  always_comb begin
    level_d      = level_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_d       = 1'b0;
    drop_count_d = drop_count_q;

    if (push_ok && !pop) begin
      level_d = level_q + LvlOne;
    end else if (pop && !push_ok) begin
      level_d = level_q - LvlOne;
    end

    // Pointer width is exactly log2(DEPTH), so the increment wraps on its own.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    if (s1_valid_q && !push_ok) begin
      drop_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  logic [31:0] res_mem_q [DEPTH];
  logic [1:0]  op_mem_q  [DEPTH];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        op_mem_q[i]  <= '0;
      end
    end else if (push_ok) begin
      res_mem_q[wr_ptr_q] <= s2_result;
      op_mem_q[wr_ptr_q]  <= s1_op_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_result = res_mem_q[rd_ptr_q];
  assign out_c      = op_mem_q[rd_ptr_q];
  assign level      = level_q;
  assign drop       = drop_q;
  assign drop_count = drop_count_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_level_bound: assert property (@(posedge clk) disable iff (!reset_n)
    level_q <= FullLevel);

  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready) |=> ($stable(out_result) && $stable(out_c)));

endmodule

// File: tb/tb_my_bus_responder.sv
// Self-checking bench for my_bus_responder. A queue-based reference model
// predicts FIFO contents, drops and the drop counter; a compare process checks
// every cycle. A second instance with CNT_W=2 shares the stimulus to exercise
// counter saturation. Directed sequences pin the model with literal values.
module tb_my_bus_responder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  c = '0;
  logic        out_ready = 1'b0;

  logic        out_valid;
  logic [31:0] out_result;
  logic [1:0]  out_c;
  logic [2:0]  level;
  logic        drop;
  logic [15:0] drop_count;

  logic        d2_out_valid;
  logic [31:0] d2_out_result;
  logic [1:0]  d2_out_c;
  logic [2:0]  d2_level;
  logic        d2_drop;
  logic [1:0]  d2_drop_count;

  my_bus_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_c      (out_c),
    .level      (level),
    .drop       (drop),
    .drop_count (drop_count)
  );

  my_bus_responder #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid      (valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .out_valid  (d2_out_valid),
    .out_ready  (out_ready),
    .out_result (d2_out_result),
    .out_c      (d2_out_c),
    .level      (d2_level),
    .drop       (d2_drop),
    .drop_count (d2_drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] r;
    logic [1:0]  op;
  } ent_t;

  ent_t mq[$];
  ent_t m_s1;
  bit   m_s1v  = 1'b0;
  bit   m_drop = 1'b0;
  int   m_cnt  = 0;

  function automatic logic [31:0] f_op(input logic [31:0] x, input logic [31:0] y,
                                       input logic [1:0] op);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_s1v  = 1'b0;
        m_drop = 1'b0;
        m_cnt  = 0;
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        m_drop = 1'b0;
        if (m_s1v) begin
          if (mq.size() < DEPTH) mq.push_back(m_s1);
          else begin
            m_drop = 1'b1;
            m_cnt++;
          end
        end
        m_s1v = valid;
        if (valid) m_s1 = '{r: f_op(a, b, c), op: c};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  bit chk_on = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), mq.size());
        chk("drop", 32'(drop), 32'(m_drop));
        chk("drop_count", 32'(drop_count), sat(m_cnt, 65535));
        chk("d2_drop_count", 32'(d2_drop_count), sat(m_cnt, 3));
        chk("d2_level", 32'(d2_level), mq.size());
        if (mq.size() != 0) begin
          chk("out_result", out_result, mq[0].r);
          chk("out_c", 32'(out_c), 32'(mq[0].op));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic beat(input bit v, input logic [31:0] x, input logic [31:0] y,
                      input logic [1:0] op);
    valid = v;
    if (v) begin
      a = x;
      b = y;
      c = op;
    end else begin
      a = 'x;
      b = 'x;
      c = 'x;
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_c", 32'(out_c), 0);
    chk("rst_d2_drop_count", 32'(d2_drop_count), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int ndrops;
  int rdy_pct;

  initial begin
    // Power-on reset
    @(negedge clk);
    #2 reset_n = 1'b1;
    chk_on = 1'b1;

    // Single beat 5-3, latency 2, then pop
    out_ready = 1'b1;
    beat(1'b1, 32'd5, 32'd3, 2'd1);
    @(negedge clk);
    chk("lat_not_early", 32'(out_valid), 0);
    beat(1'b0, '0, '0, '0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 1);
    chk("sub_result", out_result, 32'd2);
    chk("sub_c", 32'(out_c), 32'd1);
    @(negedge clk);
    chk("single_level0", 32'(level), 0);

    // Wraparound arithmetic
    beat(1'b1, 32'hFFFF_FFFF, 32'd1, 2'd0);
    @(negedge clk);
    beat(1'b1, 32'd0, 32'd1, 2'd1);
    @(negedge clk);
    chk("add_wrap", out_result, 32'h0);
    beat(1'b0, '0, '0, '0);
    @(negedge clk);
    chk("sub_wrap", out_result, 32'hFFFF_FFFF);
    @(negedge clk);

    // Overflow: DEPTH+2 beats with no consumer
    do_reset();
    out_ready = 1'b0;
    ndrops = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      beat(1'b1, 32'(100 + i), 32'd0, 2'd0);
      @(negedge clk);
      if (drop) ndrops++;
    end
    beat(1'b0, '0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (drop) ndrops++;
    end
    chk("ovf_drop_pulses", ndrops, 2);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_drop_count", 32'(drop_count), 2);
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      chk("ovf_order", out_result, 32'(100 + j));
      @(negedge clk);
    end
    chk("ovf_drained", 32'(level), 0);

    // Full FIFO with a streaming consumer: no drops, level pinned at DEPTH
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      beat(1'b1, 32'(i), 32'(7 * i), 2'(i));
      @(negedge clk);
    end
    chk("stream_full", 32'(level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
      @(negedge clk);
      chk("stream_level", 32'(level), 4);
      chk("stream_nodrop", 32'(drop), 0);
    end
    chk("stream_count", 32'(drop_count), 0);
    beat(1'b0, '0, '0, '0);
    repeat (DEPTH + 2) @(negedge clk);

    // Saturation of the narrow counter: 5 forced discards
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      beat(1'b1, 32'(i), 32'd1, 2'd3);
      @(negedge clk);
    end
    beat(1'b0, '0, '0, '0);
    @(negedge clk);
    chk("sat_wide_count", 32'(drop_count), 5);
    chk("sat_narrow_count", 32'(d2_drop_count), 3);
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);

    // Reset mid-operation: level=3 with a beat in stage 1
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 32'(50 + i), 32'd2, 2'd2);
      @(negedge clk);
    end
    chk("pre_rst_level", 32'(level), 3);
    beat(1'b1, 32'd10, 32'd20, 2'd0);
    out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    beat(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_level", 32'(level), 1);
    chk("post_rst_result", out_result, 32'd30);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic with shifting consumer rate
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (i % 200 == 0) rdy_pct = $urandom_range(0, 100);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 3) != 0) beat(1'b1, pick(), pick(), 2'($urandom_range(0, 3)));
      else beat(1'b0, '0, '0, '0);
      @(negedge clk);
    end

    beat(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (DEPTH + 3) @(negedge clk);
    chk("final_empty", 32'(level), 0);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/my_bus_responder.md
MY_BUS_RESPONDER -- requirements
Module: my_bus_responder

Interface
REQ-001 Parameter DEPTH, default 4, sets FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 16, sets the width of drop_count.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port valid  input  1  is the bus beat qualifier; the bus has no backpressure.
REQ-006 Ports a and b  input  32 each  are the bus operands.
REQ-007 Port c  input  2  is the bus opcode.
REQ-008 Port out_valid  output  1  SHALL indicate that the FIFO head holds a result.
REQ-009 Port out_ready  input  1  is the downstream accept signal.
REQ-010 Port out_result  output  32  is the computed result at the FIFO head.
REQ-011 Port out_c  output  2  is the opcode of the FIFO head entry.
REQ-012 Port level  output  $clog2(DEPTH)+1  is the current FIFO occupancy.
REQ-013 Port drop  output  1  SHALL pulse for one cycle when a beat is discarded.
REQ-014 Port drop_count  output  CNT_W  is the saturating count of discarded beats.

Function
REQ-015 Bus inputs SHALL be sampled only on the rising clk edge; this is edge N when valid=1.
REQ-016 Stage 1 SHALL register {c, a, b} and a stage-1 valid flag at edge N.
REQ-017 Stage 2 SHALL compute result from the stage-1 register and attempt a FIFO push at edge N+1.
- c=0: a+b
- c=1: a-b
- c=2: a&b
- c=3: a^b
- All arithmetic is modulo 2^32; carry and borrow are discarded.
REQ-018 With an empty FIFO and no stall, out_valid SHALL rise after edge N+1, giving a latency of 2 clocks.
REQ-019 out_result and out_c SHALL be driven directly from FIFO head storage, with no extra register.
REQ-020 A pop SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-021 out_result and out_c SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 A push with level<DEPTH SHALL be accepted and stored in arrival order.
REQ-023 A push with level==DEPTH and a simultaneous pop SHALL be accepted, and level SHALL remain DEPTH.
REQ-024 A push with level==DEPTH and no pop SHALL be discarded; drop SHALL be 1 for the following cycle.
REQ-025 On each discard, drop_count SHALL increment, saturating at 2^CNT_W-1 with no wrap.
REQ-026 A pop with level==0 SHALL be impossible; out_ready SHALL be ignored while out_valid=0.
REQ-027 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Back-to-back valid beats SHALL be accepted every cycle, giving a throughput of 1 beat per clock.
REQ-030 X on a, b or c while valid=0 SHALL NOT propagate to any output.

Reset
REQ-031 On reset_n=0, outputs SHALL take these values:
- out_valid=0
- level=0
- drop=0
- drop_count=0
- out_result=0
- out_c=0
- stage-1 valid flag and FIFO pointers cleared
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and stored beats immediately, with no further drop pulse.
REQ-033 After reset_n deassertion, a beat sampled at the first rising edge SHALL be processed normally.

Verification
REQ-034 Single beat a=5, b=3, c=1, out_ready=1 -> out_valid high after edge 2 with out_result=2 and out_c=1; level returns to 0.
REQ-035 a=32'hFFFF_FFFF, b=1, c=0 -> out_result=0; then a=0, b=1, c=1 -> out_result=32'hFFFF_FFFF.
REQ-036 out_ready=0 with DEPTH+2 consecutive beats (DEPTH=4) -> level=4, two drop pulses, drop_count=2, and the first 4 results are popped in order once out_ready=1.
REQ-037 level=4 with out_ready=1 and a continuous beat stream -> no drops; level stays 4; every beat emerges in order.
REQ-038 CNT_W=2 with 5 forced discards -> drop_count=3, saturated.
REQ-039 reset_n pulsed low while level=3 and a beat is in stage 1 -> all outputs at reset values asynchronously; no stale beat appears after release.
